// File: rtl/xcorr_pkg.sv
// rtl/xcorr_pkg.sv - shared types and widths for the xcorr IFFT arbiter
package xcorr_pkg;

  localparam int CONF_W = 8;
  localparam int EXP_W  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef logic tag_t;

endpackage

// File: rtl/xcorr_tag_fifo.sv
// rtl/xcorr_tag_fifo.sv - requester tag FIFO tracking frames launched into the IFFT
module xcorr_tag_fifo
  import xcorr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head,
  output logic full,
  output logic empty,
  output logic underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  tag_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign underflow = pop && empty;
  assign head      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_tag;
  end

endmodule

// File: rtl/xcorr_ifft_arb.sv
// rtl/xcorr_ifft_arb.sv - round-robin frame arbiter sharing one IFFT between two requesters
module xcorr_ifft_arb
  import xcorr_pkg::*;
#(
  parameter int FRAME_LEN = 1024,
  parameter int MAX_OUT   = 4,
  parameter int DW        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [CONF_W-1:0]    conf0,
  input  logic [CONF_W-1:0]    conf1,
  input  logic                 val0,
  input  logic                 val1,
  input  logic signed [DW-1:0] i0,
  input  logic signed [DW-1:0] q0,
  input  logic signed [DW-1:0] i1,
  input  logic signed [DW-1:0] q1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 busy,
  output logic                 ifft_ival,
  output logic signed [DW-1:0] ifft_i,
  output logic signed [DW-1:0] ifft_q,
  output logic [CONF_W-1:0]    ifft_conf,
  input  logic                 ifft_val,
  input  logic                 ifft_eop,
  input  logic signed [DW-1:0] ifft_di,
  input  logic signed [DW-1:0] ifft_dq,
  input  logic [EXP_W-1:0]     ifft_exp,
  output logic                 out_val,
  output logic                 out_eop,
  output logic signed [DW-1:0] out_i,
  output logic signed [DW-1:0] out_q,
  output logic [EXP_W-1:0]     out_exp,
  output logic                 out_tag,
  output logic                 err
);

  localparam int CW = $clog2(FRAME_LEN);

  state_t        state;
  state_t        state_nxt;
  logic          rr;
  logic          win;
  logic [CW-1:0] cnt;
  logic          grant;
  logic          grant_win;
  logic          stream_val;
  logic          stray_val;
  logic          last;
  tag_t          fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_underflow;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_win  = 1'b0;
    stream_val = (state == STREAM) && (win ? val1 : val0);
    stray_val  = (state == STREAM) && (win ? val0 : val1);
    last       = stream_val && (cnt == CW'(FRAME_LEN - 1));
    case (state)
      IDLE: begin
        if ((req0 || req1) && !fifo_full) begin
          grant     = 1'b1;
          grant_win = (req0 && req1) ? rr : req1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == STREAM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      win       <= 1'b0;
      cnt       <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ifft_conf <= '0;
      ifft_ival <= 1'b0;
      ifft_i    <= '0;
      ifft_q    <= '0;
      out_val   <= 1'b0;
      out_eop   <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_exp   <= '0;
      out_tag   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt0  <= grant && !grant_win;
      gnt1  <= grant && grant_win;
      // Config only moves at a grant, so it is frozen for the whole frame.
      if (grant) begin
        win       <= grant_win;
        rr        <= ~grant_win;
        ifft_conf <= grant_win ? conf1 : conf0;
      end
      if (stream_val) begin
        cnt    <= last ? '0 : cnt + 1'b1;
        ifft_i <= win ? i1 : i0;
        ifft_q <= win ? q1 : q0;
      end
      ifft_ival <= stream_val;
      out_val   <= ifft_val;
      out_eop   <= ifft_val && ifft_eop;
      out_i     <= ifft_di;
      out_q     <= ifft_dq;
      out_exp   <= ifft_exp;
      out_tag   <= fifo_empty ? 1'b0 : fifo_head;
      if (fifo_underflow || stray_val) err <= 1'b1;
    end
  end

  xcorr_tag_fifo #(
    .DEPTH(MAX_OUT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (grant),
    .push_tag (grant_win),
    .pop      (ifft_val && ifft_eop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .underflow(fifo_underflow)
  );

endmodule

// File: tb/tb_xcorr_ifft_arb.sv
// tb/tb_xcorr_ifft_arb.sv - directed self-checking bench for xcorr_ifft_arb
module tb_xcorr_ifft_arb;
  import xcorr_pkg::*;

  localparam int FL = 16;
  localparam int MO = 2;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req0, req1, val0, val1;
  logic [7:0] conf0, conf1;
  logic signed [DW-1:0] i0, q0, i1, q1;
  logic gnt0, gnt1, busy, ifft_ival;
  logic signed [DW-1:0] ifft_i, ifft_q;
  logic [7:0] ifft_conf;
  logic ifft_val, ifft_eop;
  logic signed [DW-1:0] ifft_di, ifft_dq;
  logic [4:0] ifft_exp;
  logic out_val, out_eop, out_tag, err;
  logic signed [DW-1:0] out_i, out_q;
  logic [4:0] out_exp;

  xcorr_ifft_arb #(.FRAME_LEN(FL), .MAX_OUT(MO), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .conf0(conf0), .conf1(conf1),
    .val0(val0), .val1(val1), .i0(i0), .q0(q0), .i1(i1), .q1(q1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .ifft_ival(ifft_ival), .ifft_i(ifft_i),
    .ifft_q(ifft_q), .ifft_conf(ifft_conf), .ifft_val(ifft_val), .ifft_eop(ifft_eop),
    .ifft_di(ifft_di), .ifft_dq(ifft_dq), .ifft_exp(ifft_exp), .out_val(out_val),
    .out_eop(out_eop), .out_i(out_i), .out_q(out_q), .out_exp(out_exp),
    .out_tag(out_tag), .err(err)
  );

  typedef struct {
    logic           v;
    logic           e;
    logic [DW-1:0]  di;
    logic [DW-1:0]  dq;
    logic [4:0]     ex;
    logic           tag;
  } rv_t;

  rv_t tbl [33];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; val0 = 1'b0; val1 = 1'b0;
    conf0 = '0; conf1 = '0; i0 = '0; q0 = '0; i1 = '0; q1 = '0;
    ifft_val = 1'b0; ifft_eop = 1'b0; ifft_di = '0; ifft_dq = '0; ifft_exp = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_gnt(output bit who, output int n);
    who = 1'b0;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (gnt0 || gnt1) begin
        who = gnt1;
        n = c;
        if (gnt1) req1 = 1'b0;
        else req0 = 1'b0;
        break;
      end
    end
  endtask

  task automatic stream(input bit who, input int n, input bit gap, input logic [7:0] cexp);
    int ok;
    logic [DW-1:0] ei;
    ok = 0;
    for (int k = 0; k < n; k++) begin
      if (gap && k == 5) begin
        val0 = 1'b0;
        val1 = 1'b0;
        tick;
        chk("gap_ival", 32'(ifft_ival), 32'd0);
      end
      ei = (who ? 16'd2000 : 16'd1000) + 16'(k);
      if (who) begin val1 = 1'b1; i1 = ei; q1 = ~ei; end
      else     begin val0 = 1'b1; i0 = ei; q0 = ~ei; end
      tick;
      if (ifft_ival && ifft_i == ei && ifft_q == ~ei && ifft_conf == cexp && busy == (k < FL - 1))
        ok++;
    end
    val0 = 1'b0;
    val1 = 1'b0;
    chk("stream_ok", 32'(ok), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit w;
    int n;
    int g;
    int gidx;

    for (int i = 0; i < 33; i++) begin
      tbl[i].di = 16'(i * 3 + 1);
      tbl[i].dq = 16'(100 - i);
      if (i < 16) begin
        tbl[i].v = 1'b1; tbl[i].e = (i == 15); tbl[i].ex = 5'd3; tbl[i].tag = 1'b0;
      end else if (i == 16) begin
        tbl[i].v = 1'b0; tbl[i].e = 1'b0; tbl[i].ex = 5'd0; tbl[i].tag = 1'b0;
      end else begin
        tbl[i].v = 1'b1; tbl[i].e = (i == 32); tbl[i].ex = 5'd7; tbl[i].tag = 1'b1;
      end
    end

    // Reset state
    do_reset;
    chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ival", 32'(ifft_ival), 32'd0);
    chk("rst_conf", 32'(ifft_conf), 32'd0);
    chk("rst_out", 32'({out_val, out_eop, out_tag, out_exp}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single requester frame with a sample gap
    conf0 = 8'h01;
    req0 = 1'b1;
    wait_gnt(w, n);
    chk("r0_who", 32'(w), 32'd0);
    chk("r0_lat", 32'(n), 32'd1);
    tick;
    chk("r0_pulse", 32'(gnt0), 32'd0);
    chk("r0_busy", 32'(busy), 32'd1);
    stream(1'b0, FL, 1'b1, 8'h01);

    // Second frame from requester 1 fills the tag FIFO
    conf1 = 8'h22;
    req1 = 1'b1;
    wait_gnt(w, n);
    chk("r1_who", 32'(w), 32'd1);
    chk("r1_lat", 32'(n), 32'd1);
    stream(1'b1, FL, 1'b0, 8'h22);

    // FIFO full: pending request must wait
    conf0 = 8'h33;
    req0 = 1'b1;
    g = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (gnt0 || gnt1) g++;
    end
    chk("full_nogrant", 32'(g), 32'd0);

    // Return frames 0 and 1 from the model IFFT
    gidx = -1;
    for (int i = 0; i < 33; i++) begin
      ifft_val = tbl[i].v; ifft_eop = tbl[i].e;
      ifft_di = tbl[i].di; ifft_dq = tbl[i].dq; ifft_exp = tbl[i].ex;
      tick;
      chk("ret_val", 32'(out_val), 32'(tbl[i].v));
      chk("ret_eop", 32'(out_eop), 32'(tbl[i].v & tbl[i].e));
      chk("ret_i", 32'(16'(out_i)), 32'(tbl[i].di));
      chk("ret_q", 32'(16'(out_q)), 32'(tbl[i].dq));
      chk("ret_exp", 32'(out_exp), 32'(tbl[i].ex));
      if (tbl[i].v) chk("ret_tag", 32'(out_tag), 32'(tbl[i].tag));
      if (gnt0 && gidx < 0) begin
        gidx = i;
        req0 = 1'b0;
      end
    end
    ifft_val = 1'b0; ifft_eop = 1'b0;
    chk("full_gnt_idx", 32'(gidx), 32'd16);
    chk("full_conf", 32'(ifft_conf), 32'h33);
    chk("ret_err", 32'(err), 32'd0);
    stream(1'b0, FL, 1'b0, 8'h33);

    // Both requesting: grants alternate 0,1,0,1 back-to-back
    do_reset;
    conf0 = 8'h0A; conf1 = 8'h0B;
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(w, n);
    chk("rr1_who", 32'(w), 32'd0);
    chk("rr1_lat", 32'(n), 32'd1);
    stream(1'b0, FL, 1'b0, 8'h0A);
    req0 = 1'b1;
    wait_gnt(w, n);
    chk("rr2_who", 32'(w), 32'd1);
    chk("rr2_lat", 32'(n), 32'd1);
    stream(1'b1, FL, 1'b0, 8'h0B);
    req1 = 1'b1;
    ifft_val = 1'b1; ifft_eop = 1'b1; ifft_exp = 5'd9;
    tick;
    ifft_val = 1'b0; ifft_eop = 1'b0;
    chk("rr_hold", 32'(gnt0 | gnt1), 32'd0);
    chk("rr_tag0", 32'(out_tag), 32'd0);
    chk("rr_eop0", 32'(out_eop), 32'd1);
    chk("rr_exp0", 32'(out_exp), 32'd9);
    wait_gnt(w, n);
    chk("rr3_who", 32'(w), 32'd0);
    chk("rr3_lat", 32'(n), 32'd1);
    stream(1'b0, FL, 1'b0, 8'h0A);
    ifft_val = 1'b1; ifft_eop = 1'b1;
    tick;
    ifft_val = 1'b0; ifft_eop = 1'b0;
    chk("rr_tag1", 32'(out_tag), 32'd1);
    wait_gnt(w, n);
    chk("rr4_who", 32'(w), 32'd1);
    chk("rr4_lat", 32'(n), 32'd1);
    chk("rr_err", 32'(err), 32'd0);

    // Result eop with empty tag FIFO
    do_reset;
    ifft_val = 1'b1; ifft_eop = 1'b1;
    tick;
    ifft_val = 1'b0; ifft_eop = 1'b0;
    chk("uf_err", 32'(err), 32'd1);
    chk("uf_tag", 32'(out_tag), 32'd0);
    for (int c = 0; c < 3; c++) tick;
    chk("uf_sticky", 32'(err), 32'd1);

    // Sample from the non-granted requester
    do_reset;
    chk("err_clr", 32'(err), 32'd0);
    req0 = 1'b1;
    wait_gnt(w, n);
    val1 = 1'b1;
    tick;
    val1 = 1'b0;
    chk("stray_err", 32'(err), 32'd1);
    chk("stray_ival", 32'(ifft_ival), 32'd0);

    // Reset in the middle of a frame
    do_reset;
    conf0 = 8'h5C;
    req0 = 1'b1;
    wait_gnt(w, n);
    stream(1'b0, 7, 1'b0, 8'h5C);
    val0 = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    val0 = 1'b0;
    chk("mr_ival", 32'(ifft_ival), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_conf", 32'(ifft_conf), 32'd0);
    chk("mr_outs", 32'({gnt0, gnt1, out_val, err}), 32'd0);
    req0 = 1'b1;
    wait_gnt(w, n);
    chk("mr_who", 32'(w), 32'd0);
    chk("mr_lat", 32'(n), 32'd1);
    stream(1'b0, FL, 1'b0, 8'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xcorr_ifft_arb.md
Name: xcorr_ifft_arb

Overview:
- Frame-level arbiter/sequencer that shares one correlator IFFT datapath (FIFO + IFFT core) between two requesters, e.g. two preamble-reference correlation channels.
- Grants whole frames of FRAME_LEN samples round-robin and muxes sample streams and per-requester config into the IFFT.
- Tags each launched frame and returns IFFT results with the originating requester tag and block exponent.
- Sits between the frequency-domain multiply stage and the peak detector in the Rx xcorr chain.

Parameters:
- FRAME_LEN, 1024, samples per IFFT frame (power of two, 8..4096)
- MAX_OUT, 4, max frames launched but not yet returned (tag FIFO depth, power of two)
- DW, 16, I/Q sample width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0, req1  in  1  requester wants to send one frame; held until grant seen
- conf0, conf1  in  8  IFFT config word for that requester, sampled at grant
- val0, val1  in  1  sample valid from requester (gaps allowed)
- i0, q0, i1, q1  in  DW  requester samples (signed)
- gnt0, gnt1  out  1  one-cycle grant pulse; requester then streams exactly FRAME_LEN valid samples
- busy  out  1  a frame is currently streaming
- ifft_ival  out  1  to IFFT sub ival
- ifft_i, ifft_q  out  DW  to IFFT sub data_i/data_q
- ifft_conf  out  8  to IFFT sub conf
- ifft_val, ifft_eop  in  1  from IFFT sub oval/oeop
- ifft_di, ifft_dq  in  DW  from IFFT sub odata
- ifft_exp  in  5  from IFFT sub oexp
- out_val, out_eop  out  1  result valid / last sample of frame
- out_i, out_q  out  DW  result samples
- out_exp  out  5  block exponent
- out_tag  out  1  requester index of the current result frame
- err  out  1  sticky: result eop with empty tag FIFO, or out-of-window sample

Behaviour:
- Reset (synchronous): all outputs 0; state IDLE; rr pointer = 0 (requester 0 preferred first); tag FIFO empty; sample counter 0; ifft_conf = 0; err = 0.
- States:
  - IDLE: if (req0|req1) and tag FIFO not full, pick winner: sole requester, or on conflict the one the rr pointer points to. Latch winner conf into ifft_conf, push winner index into tag FIFO, pulse gnt<winner> for one cycle, go STREAM. rr pointer <= ~winner.
  - STREAM: each winner valN=1 increments the counter. Loser valN is ignored and sets err. When count reaches FRAME_LEN-1 on a valid, reset counter and go IDLE. busy=1 throughout STREAM.
  - IDLE with FIFO full: no grant; requests stay pending.
- Input path is registered, 1-cycle latency: ifft_ival/i/q <= winner val/i/q in STREAM, else ifft_ival=0.
- ifft_conf is stable from grant through end of frame and is never changed mid-frame.
- Output path is registered, 1-cycle latency: out_val/i/q/exp/eop <= ifft inputs; out_tag = tag FIFO head at the time of that sample.
  - The tag FIFO pops on ifft_val & ifft_eop.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Pop when empty: no pop, err <= 1, out_tag = 0.
- A new grant may issue in the cycle after STREAM ends (back-to-back frames). Minimum gap between consecutive frames is 1 grant cycle.
- Reset mid-frame: the stream is aborted immediately and ifft_ival drops the next cycle. Upstream IFFT reset is handled by the shared rst.
- Counter width: clog2(FRAME_LEN). Tag FIFO pointers: clog2(MAX_OUT)+1 bits for full/empty.

Decomposition:
- Package xcorr_pkg: state enum (IDLE, STREAM), CONF_W=8, EXP_W=5, tag type.
- Sub-module xcorr_tag_fifo: 1-bit-wide sync FIFO, depth MAX_OUT, with full/empty, simultaneous push/pop support, and underflow flag.

Test Plan:
- req0 only, FRAME_LEN=16, conf0=8'h01 -> gnt0 pulse 1 cycle after req0; 16 ifft_ival pulses, each 1 cycle after val0; ifft_conf=8'h01 throughout; busy low after the 16th sample.
- req0 and req1 asserted together from reset -> grants in order 0,1,0,1; each frame 16 samples; no overlap of ifft_ival sources.
- Model IFFT returns frames 0,1 with eop -> out_tag=0 for the first 16 outputs, 1 for the next 16; out_eop on samples 15 and 31; out_exp equals the injected value delayed 1 cycle.
- MAX_OUT=2, launch 2 frames with no results returned -> third req held, no grant; one eop returned -> grant issued in the next IDLE cycle.
- ifft_eop injected with empty FIFO -> err=1 and stays 1 until rst.
- rst asserted at sample 7 of a frame -> next cycle: ifft_ival=0, busy=0, all outputs 0; a fresh req0 is granted normally with the counter restarting at 0.
